// File: rtl/inst_rom_loader.sv
// ============================================================================
// Module   : inst_rom_loader
// Summary  : Instruction ROM with a valid/ready program loader; holds the core
//            in reset until a program is loaded. Optional: BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_loader #(
    parameter int              DW       = 32,
    parameter int              AW       = 32,
    parameter int              MEM_NUM  = 4096,
    parameter logic [DW-1:0]   NOP_INST = 32'h00000013
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] inst_addr_i,
    output logic [DW-1:0] inst_o,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic [DW-1:0] load_data_i,
    input  logic          load_last_i,
    input  logic [DW-1:0] load_sum_i,
    input  logic          reload_i,
    output logic          core_rstn_o,
    output logic          load_done_o,
    output logic          load_err_o
);

    localparam int            IW        = $clog2(MEM_NUM);
    localparam logic [IW-1:0] c_PTR_MAX = IW'(MEM_NUM - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_wr_ptr;
    logic            r_ready;
    logic            r_core_rstn;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_mem [0:MEM_NUM-1];

    logic            w_accept;
    logic            w_in_range;
    logic [IW-1:0]   w_index;
    logic            w_unused_addr;

    assign w_accept      = load_valid_i && r_ready;
    assign w_index       = inst_addr_i[IW+1:2];
    assign w_unused_addr = ^inst_addr_i[1:0];

`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0] r_sum;
    logic          w_sum_ok;
    // The last word is folded into the sum before comparing.
    assign w_sum_ok = ((r_sum + load_data_i) == load_sum_i);
`else
    logic w_unused_sum;
    assign w_unused_sum = ^load_sum_i;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_LOAD;
            r_wr_ptr    <= '0;
            r_ready     <= 1'b1;
            r_core_rstn <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_wr_ptr != c_PTR_MAX) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
`ifdef BOOT_CHECKSUM_EN
                        r_sum <= r_sum + load_data_i;
`endif
                        if (load_last_i) begin
                            r_ready <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                            if (w_sum_ok) begin
                                r_state <= S_RUN;
                            end else begin
                                r_state <= S_FAULT;
                                r_err   <= 1'b1;
                            end
`else
                            r_state <= S_RUN;
`endif
                        end else if (r_wr_ptr == c_PTR_MAX) begin
                            // Memory full without a last flag: run what we have, flag it.
                            r_state <= S_RUN;
                            r_err   <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_RUN, S_FAULT: begin
                    if (reload_i) begin
                        r_state     <= S_LOAD;
                        r_wr_ptr    <= '0;
                        r_ready     <= 1'b1;
                        r_core_rstn <= 1'b0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        r_sum       <= '0;
`endif
                    end else if (r_state == S_RUN) begin
                        r_core_rstn <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Contents survive reset and reload on purpose.
    always_ff @(posedge clk) begin
        if (w_accept && rstn) begin
            r_mem[r_wr_ptr] <= load_data_i;
        end
    end

    if (AW - 2 > IW) begin : g_range_check
        assign w_in_range = ~|inst_addr_i[AW-1:IW+2];
    end else begin : g_range_full
        assign w_in_range = 1'b1;
    end

    assign inst_o = ((r_state == S_RUN) && r_core_rstn && w_in_range) ? r_mem[w_index] : NOP_INST;

    assign load_ready_o = r_ready;
    assign core_rstn_o  = r_core_rstn;
    assign load_done_o  = r_done;
    assign load_err_o   = r_err;

endmodule

`default_nettype wire
